// File: rtl/risc_pkg.sv
// Shared constants and types for the RISC execute->writeback slice.
// RISC_EXWB_FWD_EN (optional) enables the operand-forwarding outputs on risc_ex_wb_stage.
package risc_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  localparam int PSR_C = 0;
  localparam int PSR_V = 1;
  localparam int PSR_Z = 2;
  localparam int PSR_N = 3;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] dr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/risc_skid_buf.sv
// Two-entry FIFO of writeback entries with a registered input ready.
// RISC_EXWB_FWD_EN exposes the buffered entries so the top can forward from them.
module risc_skid_buf
  import risc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_entry,
  output logic      out_valid,
  input  logic      out_ready,
  output wb_entry_t out_entry
`ifdef RISC_EXWB_FWD_EN
  ,
  output wb_entry_t        buf_entry [DEPTH],
  output logic [DEPTH-1:0] buf_valid
`endif
);

  logic [1:0] count_reg, count_next;
  logic       ready_reg, ready_next;
  logic       accept, pop;
  logic [1:0] wr_idx;
  wb_entry_t  entry_reg  [DEPTH];
  wb_entry_t  entry_next [DEPTH];

  assign accept = in_valid & ready_reg & ~flush;
  assign pop    = (count_reg != 2'd0) & out_ready & ~flush;
  // An accept lands behind whatever survives this cycle's pop.
  assign wr_idx = count_reg - {1'b0, pop};

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = 2'd0;
    else
      count_next = count_reg + {1'b0, accept} - {1'b0, pop};
    ready_next = (count_next < 2'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      ready_reg <= 1'b1;
    end else begin
      count_reg <= count_next;
      ready_reg <= ready_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Head only shifts when a second entry is behind it, so it holds while empty.
      if (gi < DEPTH - 1) begin : g_shift
        always_comb begin
          entry_next[gi] = entry_reg[gi];
          if (accept && wr_idx == 2'(gi))
            entry_next[gi] = in_entry;
          else if (pop && count_reg == 2'(gi + 2))
            entry_next[gi] = entry_reg[gi+1];
        end
      end else begin : g_tail
        always_comb begin
          entry_next[gi] = entry_reg[gi];
          if (accept && wr_idx == 2'(gi))
            entry_next[gi] = in_entry;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          entry_reg[gi] <= '0;
        else
          entry_reg[gi] <= entry_next[gi];
      end

`ifdef RISC_EXWB_FWD_EN
      assign buf_entry[gi] = entry_reg[gi];
      assign buf_valid[gi] = (count_reg > 2'(gi));
`endif
    end
  endgenerate

  assign in_ready  = ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_entry = entry_reg[0];

endmodule

// File: rtl/risc_ex_wb_stage.sv
// Execute->writeback stage: skid-buffered results, PSR update and register-file write port.
// Define RISC_EXWB_FWD_EN to add fwd_valid/fwd_addr/fwd_data forwarding outputs.
module risc_ex_wb_stage
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_c,
  input  logic          ex_v,
  input  logic          ex_z,
  input  logic          ex_n,
  input  logic          ex_mf,
  input  logic          ex_sf,
  input  logic          ex_rw,
  input  logic [AW-1:0] ex_dr,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [3:0]    psr
`ifdef RISC_EXWB_FWD_EN
  ,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data
`endif
);

  wb_entry_t in_entry, head;
  logic      accept;
  logic [3:0] psr_reg, psr_next;

`ifdef RISC_EXWB_FWD_EN
  wb_entry_t        buf_entry [DEPTH];
  logic [DEPTH-1:0] buf_valid;
`endif

  assign in_entry = '{rw: ex_rw, dr: ex_dr, data: ex_result};

  risc_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_entry  (in_entry),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_entry (head)
`ifdef RISC_EXWB_FWD_EN
    ,
    .buf_entry (buf_entry),
    .buf_valid (buf_valid)
`endif
  );

  assign wb_we   = wb_valid & head.rw & (head.dr != '0);
  assign wb_addr = head.dr;
  assign wb_data = head.data;

  // Flags follow accept order; shifter ops leave V and C untouched.
  assign accept = ex_valid & ex_ready & ~flush;

  always_comb begin
    psr_next = psr_reg;
    if (accept && ex_sf) begin
      psr_next[PSR_N] = ex_n;
      psr_next[PSR_Z] = ex_z;
      if (!ex_mf) begin
        psr_next[PSR_V] = ex_v;
        psr_next[PSR_C] = ex_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      psr_reg <= 4'b0000;
    else
      psr_reg <= psr_next;
  end

  assign psr = psr_reg;

`ifdef RISC_EXWB_FWD_EN
  logic [DEPTH-1:0] fwd_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
      assign fwd_hit[gi] = buf_valid[gi] & buf_entry[gi].rw & (buf_entry[gi].dr != '0);
    end
  endgenerate

  // Higher index is newer, so later matches override earlier ones.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_hit[i]) begin
        fwd_valid = 1'b1;
        fwd_addr  = buf_entry[i].dr;
        fwd_data  = buf_entry[i].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_risc_ex_wb_stage.sv
// Directed self-checking bench for risc_ex_wb_stage (forwarding checks under RISC_EXWB_FWD_EN).
module tb_risc_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic        ex_c, ex_v, ex_z, ex_n;
  logic        ex_mf, ex_sf, ex_rw;
  logic [4:0]  ex_dr;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  psr;
`ifdef RISC_EXWB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  risc_ex_wb_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_result (ex_result),
    .ex_c      (ex_c),
    .ex_v      (ex_v),
    .ex_z      (ex_z),
    .ex_n      (ex_n),
    .ex_mf     (ex_mf),
    .ex_sf     (ex_sf),
    .ex_rw     (ex_rw),
    .ex_dr     (ex_dr),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .psr       (psr)
`ifdef RISC_EXWB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                       input logic rw, input logic sf, input logic mf, input logic [3:0] nzvc);
    ex_valid  = v;
    ex_result = r;
    ex_dr     = d;
    ex_rw     = rw;
    ex_sf     = sf;
    ex_mf     = mf;
    ex_n      = nzvc[3];
    ex_z      = nzvc[2];
    ex_v      = nzvc[1];
    ex_c      = nzvc[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle
    check("rst_psr",      psr,      4'b0000);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_we",    wb_we,    1'b0);
    check("rst_wb_addr",  wb_addr,  5'd0);
    check("rst_wb_data",  wb_data,  32'h0);
    check("rst_ex_ready", ex_ready, 1'b1);
    step();
    check("idle_wb_valid", wb_valid, 1'b0);

    // Single accept, ALU op with C=1
    wb_ready = 1'b1;
    drive(1'b1, 32'h0000_00A5, 5'd3, 1'b1, 1'b1, 1'b0, 4'b0001);
    step();
    ex_valid = 1'b0;
    check("single_valid", wb_valid, 1'b1);
    check("single_we",    wb_we,    1'b1);
    check("single_addr",  wb_addr,  5'd3);
    check("single_data",  wb_data,  32'hA5);
    check("single_psr",   psr,      4'b0001);
    step();
    check("single_popped",    wb_valid, 1'b0);
    check("single_data_hold", wb_data,  32'hA5);

    // Stream four results with wb_ready low: only two fit
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 5'(1 + i), 1'b1, 1'b0, 1'b0, 4'b0000);
      step();
      if (i == 0) check("stream_ready_after1", ex_ready, 1'b1);
      if (i == 1) check("stream_ready_after2", ex_ready, 1'b0);
    end
    ex_valid = 1'b0;
    check("stream_full_ready", ex_ready, 1'b0);
    check("stream_head_valid", wb_valid, 1'b1);
    check("stream_head_data",  wb_data,  32'h10);
    check("stream_head_addr",  wb_addr,  5'd1);
    wb_ready = 1'b1;
    step();
    check("stream_pop1_valid", wb_valid, 1'b1);
    check("stream_pop1_data",  wb_data,  32'h11);
    check("stream_pop1_addr",  wb_addr,  5'd2);
    check("stream_pop1_ready", ex_ready, 1'b1);
    step();
    check("stream_empty",      wb_valid, 1'b0);
    check("stream_data_hold",  wb_data,  32'h11);
    check("stream_psr",        psr,      4'b0001);

    // PSR: ALU sets V,C; shifter loads N,Z only
    drive(1'b1, 32'h1, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0011);
    step();
    check("psr_alu", psr, 4'b0011);
    drive(1'b1, 32'h8000_0000, 5'd9, 1'b1, 1'b1, 1'b1, 4'b1000);
    step();
    ex_valid = 1'b0;
    check("psr_shift",       psr,      4'b1011);
    check("psr_shift_valid", wb_valid, 1'b1);
    check("psr_shift_data",  wb_data,  32'h8000_0000);
    step();
    check("psr_drain", wb_valid, 1'b0);

    // R0 destination and rw=0 pass through without writing
    wb_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    ex_valid = 1'b0;
    check("r0_valid", wb_valid, 1'b1);
    check("r0_we",    wb_we,    1'b0);
    check("r0_data",  wb_data,  32'h55);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    drive(1'b1, 32'h66, 5'd7, 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    ex_valid = 1'b0;
    check("norw_valid", wb_valid, 1'b1);
    check("norw_we",    wb_we,    1'b0);
    check("norw_addr",  wb_addr,  5'd7);
    wb_ready = 1'b1;
    step();
    check("norw_drain", wb_valid, 1'b0);

    // Flush with a full buffer and a flag-setting input pending
    wb_ready = 1'b0;
    drive(1'b1, 32'h70, 5'd1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    drive(1'b1, 32'h71, 5'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    check("flush_full_ready", ex_ready, 1'b0);
    drive(1'b1, 32'h72, 5'd3, 1'b1, 1'b1, 1'b0, 4'b0100);
    flush    = 1'b1;
    wb_ready = 1'b1;
    step();
    flush    = 1'b0;
    ex_valid = 1'b0;
    wb_ready = 1'b0;
    check("flush_valid", wb_valid, 1'b0);
    check("flush_ready", ex_ready, 1'b1);
    check("flush_psr",   psr,      4'b1011);

    // Flush cancels an otherwise-acceptable input (count=1, ready=1)
    drive(1'b1, 32'h80, 5'd4, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    drive(1'b1, 32'h81, 5'd5, 1'b1, 1'b1, 1'b0, 4'b0100);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    ex_valid = 1'b0;
    check("flush2_valid", wb_valid, 1'b0);
    check("flush2_psr",   psr,      4'b1011);
    drive(1'b1, 32'h90, 5'd6, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    ex_valid = 1'b0;
    check("postflush_valid", wb_valid, 1'b1);
    check("postflush_data",  wb_data,  32'h90);
    check("postflush_addr",  wb_addr,  5'd6);
    wb_ready = 1'b1;
    step();
    check("postflush_drain", wb_valid, 1'b0);

    // Asynchronous reset mid-operation
    wb_ready = 1'b0;
    drive(1'b1, 32'h99, 5'd10, 1'b1, 1'b1, 1'b0, 4'b1111);
    step();
    ex_valid = 1'b0;
    check("arst_pre_psr",   psr,      4'b1111);
    check("arst_pre_valid", wb_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", wb_valid, 1'b0);
    check("arst_psr",   psr,      4'b0000);
    check("arst_data",  wb_data,  32'h0);
    check("arst_ready", ex_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef RISC_EXWB_FWD_EN
    // Forwarding picks the newest qualifying entry
    check("fwd_idle", fwd_valid, 1'b0);
    drive(1'b1, 32'h11, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    check("fwd1_valid", fwd_valid, 1'b1);
    check("fwd1_data",  fwd_data,  32'h11);
    drive(1'b1, 32'h22, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    ex_valid = 1'b0;
    check("fwd2_valid", fwd_valid, 1'b1);
    check("fwd2_addr",  fwd_addr,  5'd5);
    check("fwd2_data",  fwd_data,  32'h22);
    wb_ready = 1'b1;
    repeat (2) step();
    check("fwd_empty", fwd_valid, 1'b0);
    wb_ready = 1'b0;
    drive(1'b1, 32'h33, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    ex_valid = 1'b0;
    check("fwd_r0", fwd_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
